// File: rtl/ep_init_pkg.sv
// Shared types, endpoint register map and init table contents for the WR endpoint bring-up sequencer.
package ep_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_RETRY,
        ST_DONE,
        ST_FAIL,
        ST_VISSUE,
        ST_VWAIT
    } t_ep_init_state;

    typedef struct packed {
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [31:0] mask;
    } t_ep_init_entry;

    localparam int c_EP_INIT_N_ENTRIES = 4;

    // Endpoint sys-bus word addresses
    localparam logic [6:0] c_ADR_ECR  = 7'h00;
    localparam logic [6:0] c_ADR_TSCR = 7'h01;
    localparam logic [6:0] c_ADR_RFCR = 7'h02;
    localparam logic [6:0] c_ADR_VCR0 = 7'h0A;

    localparam logic [31:0] c_ECR_TX_EN   = 32'h0000_0040;
    localparam logic [31:0] c_ECR_RX_EN   = 32'h0000_0080;
    localparam logic [31:0] c_TSCR_EN_RXTS = 32'h0000_0002;
    localparam int c_RFCR_MRU_OFFSET   = 12;
    localparam int c_RFCR_MRU_WIDTH    = 14;
    localparam int c_VCR0_QMODE_OFFSET = 0;
    localparam int c_VCR0_QMODE_WIDTH  = 2;

    // Values wider than their register field are truncated to the field.
    function automatic t_ep_init_entry ep_init_entry(input int idx, input int mru, input int qmode);
        t_ep_init_entry e;
        logic [31:0] fmask;
        e = '0;
        fmask = '0;
        case (idx)
            0: begin
                e.adr  = c_ADR_ECR;
                e.mask = c_ECR_TX_EN | c_ECR_RX_EN;
                e.dat  = e.mask;
            end
            1: begin
                fmask  = ((32'd1 << c_RFCR_MRU_WIDTH) - 32'd1) << c_RFCR_MRU_OFFSET;
                e.adr  = c_ADR_RFCR;
                e.mask = fmask;
                e.dat  = (32'(mru) << c_RFCR_MRU_OFFSET) & fmask;
            end
            2: begin
                fmask  = ((32'd1 << c_VCR0_QMODE_WIDTH) - 32'd1) << c_VCR0_QMODE_OFFSET;
                e.adr  = c_ADR_VCR0;
                e.mask = fmask;
                e.dat  = (32'(qmode) << c_VCR0_QMODE_OFFSET) & fmask;
            end
            default: begin
                e.adr  = c_ADR_TSCR;
                e.mask = c_TSCR_EN_RXTS;
                e.dat  = c_TSCR_EN_RXTS;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ep_init_timeout_cnt.sv
// Loadable saturating down-counter; zero flag bounds each bus access of the init sequencer.
module ep_init_timeout_cnt (
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        zero
);
    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && count_reg != 16'd0) begin
            count_reg <= count_reg - 16'd1;
        end
    end

    assign zero = (count_reg == 16'd0);
endmodule

// File: rtl/ep_init_sequencer.sv
// WR endpoint bring-up: writes ECR, RFCR, VCR0, TSCR over classic Wishbone with timeout/error retry.
// Optional read-back verification of every write when EP_INIT_VERIFY_EN is defined.
module ep_init_sequencer
    import ep_init_pkg::*;
#(
    parameter int g_mru         = 1518,
    parameter int g_qmode       = 3,
    parameter int g_auto_start  = 1,
    parameter int g_timeout     = 255,
    parameter int g_max_retries = 3
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  fail_idx_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [6:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    // Loaded one short: the ISSUE cycle also counts, so a full attempt spans g_timeout cycles.
    localparam logic [15:0] c_TIMER_INIT = 16'(g_timeout - 1);
    localparam logic [3:0]  c_MAX_RETRY  = 4'(g_max_retries);

    t_ep_init_state state_reg;
    logic [1:0]  idx_reg;
    logic [3:0]  retry_reg;
    logic        auto_arm_reg;
    logic        busy_reg, done_reg, error_reg, cyc_reg, we_reg;
    logic [1:0]  fail_idx_reg;
    logic [6:0]  adr_reg;
    logic [31:0] dat_reg;
    logic        timer_load, timer_en, timer_zero;

    t_ep_init_entry entry_table [c_EP_INIT_N_ENTRIES];

    generate
        for (genvar gi = 0; gi < c_EP_INIT_N_ENTRIES; gi++) begin : g_table
            assign entry_table[gi] = ep_init_entry(gi, g_mru, g_qmode);
        end
    endgenerate

`ifdef EP_INIT_VERIFY_EN
    logic verify_bad;
    assign verify_bad = ((wb_dat_i ^ entry_table[idx_reg].dat) & entry_table[idx_reg].mask) != 32'd0;
`else
    logic [c_EP_INIT_N_ENTRIES-1:0] unused_mask;
    logic unused_dat;
    generate
        for (genvar gi = 0; gi < c_EP_INIT_N_ENTRIES; gi++) begin : g_unused
            assign unused_mask[gi] = ^entry_table[gi].mask;
        end
    endgenerate
    assign unused_dat = ^wb_dat_i;
`endif

    always_comb begin
        timer_load = 1'b0;
        case (state_reg)
            ST_IDLE:   timer_load = start_i || auto_arm_reg;
            ST_NEXT:   timer_load = (idx_reg != 2'd3);
            ST_RETRY:  timer_load = (retry_reg != c_MAX_RETRY);
            ST_VISSUE: timer_load = 1'b1;
            default:   timer_load = 1'b0;
        endcase
    end

    assign timer_en = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT) || (state_reg == ST_VWAIT);

    ep_init_timeout_cnt u_timeout (
        .clk      (clk_sys_i),
        .srst     (rst_i),
        .load     (timer_load),
        .load_val (c_TIMER_INIT),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            retry_reg    <= '0;
            auto_arm_reg <= (g_auto_start != 0);
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            fail_idx_reg <= '0;
            cyc_reg      <= 1'b0;
            we_reg       <= 1'b0;
            adr_reg      <= '0;
            dat_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (start_i || auto_arm_reg) begin
                    auto_arm_reg <= 1'b0;
                    idx_reg      <= '0;
                    retry_reg    <= '0;
                    busy_reg     <= 1'b1;
                    done_reg     <= 1'b0;
                    error_reg    <= 1'b0;
                    fail_idx_reg <= '0;
                    cyc_reg      <= 1'b1;
                    we_reg       <= 1'b1;
                    adr_reg      <= entry_table[0].adr;
                    dat_reg      <= entry_table[0].dat;
                    state_reg    <= ST_ISSUE;
                end
                ST_ISSUE: state_reg <= ST_WAIT;
                ST_WAIT: begin
                    // err beats ack; ack beats a timeout landing on the same edge
                    if (wb_err_i) begin
                        cyc_reg   <= 1'b0;
                        state_reg <= ST_RETRY;
                    end else if (wb_ack_i) begin
                        cyc_reg   <= 1'b0;
`ifdef EP_INIT_VERIFY_EN
                        state_reg <= ST_VISSUE;
`else
                        state_reg <= ST_NEXT;
`endif
                    end else if (timer_zero) begin
                        cyc_reg   <= 1'b0;
                        state_reg <= ST_RETRY;
                    end
                end
`ifdef EP_INIT_VERIFY_EN
                ST_VISSUE: begin
                    cyc_reg   <= 1'b1;
                    we_reg    <= 1'b0;
                    state_reg <= ST_VWAIT;
                end
                ST_VWAIT: begin
                    if (wb_err_i || (wb_ack_i && verify_bad)) begin
                        cyc_reg   <= 1'b0;
                        state_reg <= ST_RETRY;
                    end else if (wb_ack_i) begin
                        cyc_reg   <= 1'b0;
                        state_reg <= ST_NEXT;
                    end else if (timer_zero) begin
                        cyc_reg   <= 1'b0;
                        state_reg <= ST_RETRY;
                    end
                end
`endif
                ST_NEXT: begin
                    if (idx_reg == 2'd3) begin
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 2'd1;
                        retry_reg <= '0;
                        cyc_reg   <= 1'b1;
                        we_reg    <= 1'b1;
                        adr_reg   <= entry_table[idx_reg + 2'd1].adr;
                        dat_reg   <= entry_table[idx_reg + 2'd1].dat;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_RETRY: begin
                    if (retry_reg == c_MAX_RETRY) begin
                        state_reg <= ST_FAIL;
                    end else begin
                        retry_reg <= retry_reg + 4'd1;
                        cyc_reg   <= 1'b1;
                        we_reg    <= 1'b1;
                        adr_reg   <= entry_table[idx_reg].adr;
                        dat_reg   <= entry_table[idx_reg].dat;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_FAIL: begin
                    error_reg    <= 1'b1;
                    fail_idx_reg <= idx_reg;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign error_o    = error_reg;
    assign fail_idx_o = fail_idx_reg;
    assign wb_cyc_o   = cyc_reg;
    assign wb_stb_o   = cyc_reg;
    assign wb_we_o    = we_reg;
    assign wb_sel_o   = 4'hF;
    assign wb_adr_o   = adr_reg;
    assign wb_dat_o   = dat_reg;
endmodule
